// File: rtl/ddr3_mem_responder.sv
// Behavioural DDR3 memory responder: bank/row tracking, fixed BL8 bursts, CL/CWL latency.
// Define DDR3_MEM_ERR_CHK_EN to build the sticky PROTO_ERR protocol checker.
module ddr3_mem_responder #(
  parameter int ROW_W = 4,
  parameter int COL_W = 10,
  parameter int CL    = 5,
  parameter int CWL   = 5
) (
  input  logic        CPU_CLK,
  input  logic        RESET_N,
  input  logic        CKE_N,
  input  logic        CS_N,
  input  logic        RAS_N,
  input  logic        CAS_N,
  input  logic        WE_N,
  input  logic [2:0]  BA,
  input  logic [14:0] ADDR,
  inout  wire  [7:0]  DQ,
  inout  wire         DM,
  inout  wire         DQS,
  output logic        PROTO_ERR
);

  localparam int AW = 3 + ROW_W + COL_W;

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST
  } state_t;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_RSV = 3'b110,
    CMD_NOP = 3'b111
  } cmd_t;

  state_t             state, state_n;
  cmd_t               cmd;
  logic [3:0]         lat, lat_n;
  logic [2:0]         beat, beat_n;
  logic               load, wr_en, rd_oe;
  logic [2:0]         bank_r;
  logic [ROW_W-1:0]   row_r;
  logic [COL_W-4:0]   col_r;
  logic [7:0]         open_q;
  logic [ROW_W-1:0]   row_tbl [8];
  logic [AW-1:0]      addr_idx;
  logic [7:0]         mem [0:(1<<AW)-1];
  logic               unused_addr;

  assign unused_addr = ^ADDR;

  always_comb begin
    cmd = CMD_NOP;
    if (!CKE_N && !CS_N) cmd = cmd_t'({RAS_N, CAS_N, WE_N});
  end

  always_comb begin
    state_n = state;
    lat_n   = lat;
    beat_n  = beat;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd == CMD_RD && open_q[BA]) begin
          state_n = RD_WAIT;
          lat_n   = 4'(CL - 1);
          beat_n  = '0;
          load    = 1'b1;
        end else if (cmd == CMD_WR && open_q[BA]) begin
          state_n = WR_WAIT;
          lat_n   = 4'(CWL - 1);
          beat_n  = '0;
          load    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (lat == '0) state_n = RD_BURST;
        else           lat_n   = lat - 4'd1;
      end
      RD_BURST: begin
        beat_n = beat + 3'd1;
        if (beat == 3'd7) state_n = IDLE;
      end
      // Beat 0 is captured on the last wait edge so CWL=1 needs no extra state.
      WR_WAIT: begin
        if (lat == '0) begin
          wr_en   = 1'b1;
          beat_n  = beat + 3'd1;
          state_n = WR_BURST;
        end else begin
          lat_n = lat - 4'd1;
        end
      end
      WR_BURST: begin
        wr_en  = 1'b1;
        beat_n = beat + 3'd1;
        if (beat == 3'd7) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      lat     <= '0;
      beat    <= '0;
      bank_r  <= '0;
      row_r   <= '0;
      col_r   <= '0;
      open_q  <= '0;
      row_tbl <= '{default: '0};
    end else begin
      state <= state_n;
      lat   <= lat_n;
      beat  <= beat_n;
      if (load) begin
        bank_r <= BA;
        row_r  <= row_tbl[BA];
        col_r  <= ADDR[COL_W-1:3];
      end
      if (state == IDLE) begin
        if (cmd == CMD_ACT) begin
          open_q[BA]  <= 1'b1;
          row_tbl[BA] <= ADDR[ROW_W-1:0];
        end else if (cmd == CMD_PRE) begin
          if (ADDR[10]) open_q     <= '0;
          else          open_q[BA] <= 1'b0;
        end
      end
    end
  end

  assign addr_idx = {bank_r, row_r, col_r, beat};

  // Storage survives reset; write enable is already low while reset holds the FSM idle.
  always_ff @(posedge CPU_CLK) begin
    if (wr_en && !DM) mem[addr_idx] <= DQ;
  end

  assign rd_oe = (state == RD_BURST);
  assign DQ    = rd_oe ? mem[addr_idx] : 8'bz;
  assign DQS   = rd_oe ? ~beat[0] : 1'bz;

`ifdef DDR3_MEM_ERR_CHK_EN
  logic err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (state != IDLE) begin
      err_hit = (cmd != CMD_NOP);
    end else begin
      if ((cmd == CMD_RD || cmd == CMD_WR) && !open_q[BA]) err_hit = 1'b1;
      if (cmd == CMD_ACT && open_q[BA])                    err_hit = 1'b1;
      if ((cmd == CMD_REF || cmd == CMD_MRS) && |open_q)   err_hit = 1'b1;
    end
  end

  always_ff @(posedge CPU_CLK or negedge RESET_N) begin
    if (!RESET_N)     PROTO_ERR <= 1'b0;
    else if (err_hit) PROTO_ERR <= 1'b1;
  end
`else
  assign PROTO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_mem_responder.sv
// Scoreboard bench for ddr3_mem_responder: directed scenarios plus randomized command traffic.
module tb_ddr3_mem_responder;

  localparam int ROW_W = 4;
  localparam int COL_W = 10;
  localparam int CL    = 5;
  localparam int CWL   = 5;
`ifdef DDR3_MEM_ERR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_NOP = 3'b111;
  localparam int NEVER = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke_n = 1'b0, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [14:0] addr = '0;
  logic [7:0]  dq_drv = '0;
  logic        dq_en = 1'b0;
  logic        dm_drv = 1'b0;
  logic        proto_err;
  wire  [7:0]  dq;
  wire         dm;
  wire         dqs;

  assign dq = dq_en ? dq_drv : 8'bz;
  assign dm = dm_drv;

  // Undriven bus reads back as all ones.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (dq[g]);
  end
  pullup (dqs);

  ddr3_mem_responder #(.ROW_W(ROW_W), .COL_W(COL_W), .CL(CL), .CWL(CWL)) dut (
    .CPU_CLK(clk), .RESET_N(rst_n), .CKE_N(cke_n), .CS_N(cs_n), .RAS_N(ras_n),
    .CAS_N(cas_n), .WE_N(we_n), .BA(ba), .ADDR(addr), .DQ(dq), .DM(dm), .DQS(dqs),
    .PROTO_ERR(proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         known;
    bit         dqs;
  } exp_t;

  exp_t       sb[$];
  bit         m_open[8];
  int         m_row[8];
  logic [7:0] m_mem[int];
  logic [7:0] wd_dq[int];
  bit         wd_dm[int];
  int         idle_from = 0;
  int         perr_at = NEVER;
  logic [7:0] wdata[8];
  bit         wmask[8];

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].at == cyc) begin
      e = sb.pop_front();
      check("rd_dqs", {31'd0, dqs}, {31'd0, e.dqs});
      if (e.known) check("rd_dq", {24'd0, dq}, {24'd0, e.d});
    end else if (sb.size() > 0 && sb[0].at < cyc) begin
      e = sb.pop_front();
      check("rd_missed", 32'(cyc), 32'(e.at));
    end else if (!dq_en) begin
      check("dq_z", {24'd0, dq}, 32'hFF);
      check("dqs_z", {31'd0, dqs}, 32'd1);
    end
    check("proto_err", {31'd0, proto_err}, {31'd0, (CHK && cyc >= perr_at)});
  end

  function automatic int mem_idx(int b, int r, logic [14:0] a, int i);
    return (((b * (1 << ROW_W) + r) * (1 << (COL_W - 3)) + int'(a[COL_W-1:3])) * 8) + i;
  endfunction

  task automatic flag(input int t);
    if (perr_at > t) perr_at = t;
  endtask

  function automatic bit any_open();
    bit o = 1'b0;
    for (int i = 0; i < 8; i++) o |= m_open[i];
    return o;
  endfunction

  // Reference model: applies a command accepted at edge t.
  task automatic model_cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a, input int t);
    int k;
    if (t < idle_from) begin
      if (c != C_NOP) flag(t);
      return;
    end
    case (c)
      C_ACT: begin
        if (m_open[b]) flag(t);
        m_open[b] = 1'b1;
        m_row[b]  = int'(a[ROW_W-1:0]);
      end
      C_PRE: begin
        if (a[10]) for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
        else m_open[b] = 1'b0;
      end
      C_RD: begin
        if (!m_open[b]) flag(t);
        else begin
          for (int i = 0; i < 8; i++) begin
            k = mem_idx(b, m_row[b], a, i);
            sb.push_back('{at: t + CL + i, d: m_mem.exists(k) ? m_mem[k] : 8'h00,
                           known: m_mem.exists(k), dqs: (i % 2 == 0)});
          end
          idle_from = t + CL + 9;
        end
      end
      C_WR: begin
        if (!m_open[b]) flag(t);
        else begin
          for (int i = 0; i < 8; i++) begin
            wd_dq[t + CWL + i] = wdata[i];
            wd_dm[t + CWL + i] = wmask[i];
            if (!wmask[i]) m_mem[mem_idx(b, m_row[b], a, i)] = wdata[i];
          end
          idle_from = t + CWL + 8;
        end
      end
      C_REF, C_MRS: if (any_open()) flag(t);
      default: ;
    endcase
  endtask

  // Advance one edge; idle cycles use assorted deselect/NOP encodings.
  task automatic step();
    int mode;
    @(posedge clk);
    #1;
    mode = $urandom_range(0, 2);
    cke_n = (mode == 2);
    cs_n  = (mode == 1);
    {ras_n, cas_n, we_n} = (mode == 0) ? C_NOP : 3'($urandom);
    ba   = 3'($urandom);
    addr = 15'($urandom);
    if (wd_dq.exists(cyc + 1)) begin
      dq_en  = 1'b1;
      dq_drv = wd_dq[cyc + 1];
      dm_drv = wd_dm[cyc + 1];
    end else begin
      dq_en  = 1'b0;
      dm_drv = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    cke_n = 1'b0;
    cs_n  = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
    model_cmd(c, b, a, cyc + 1);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dq_en = 1'b0;
    sb.delete();
    wd_dq.delete();
    wd_dm.delete();
    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
    idle_from = 0;
    perr_at   = NEVER;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    while (cyc + 1 < idle_from) step();
  endtask

  task automatic set_data(input logic [7:0] base, input int masked);
    for (int i = 0; i < 8; i++) begin
      wdata[i] = 8'(base * (i + 1));
      wmask[i] = (i == masked);
    end
  endtask

  initial begin
    logic [14:0] a;
    logic [2:0]  b;
    int          r;

    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic write then read of the same burst.
    issue(C_ACT, 3'd2, 15'd5);
    set_data(8'h11, -1);
    issue(C_WR, 3'd2, 15'h010);
    wait_idle();
    issue(C_RD, 3'd2, 15'h010);
    repeat (16) step();

    // Masked beat over prior 0xAA contents.
    for (int i = 0; i < 8; i++) begin wdata[i] = 8'hAA; wmask[i] = 1'b0; end
    issue(C_WR, 3'd2, 15'h010);
    wait_idle();
    set_data(8'h11, 3);
    issue(C_WR, 3'd2, 15'h010);
    wait_idle();
    issue(C_RD, 3'd2, 15'h013);
    repeat (16) step();

    // Read of an unopened bank.
    issue(C_RD, 3'd4, 15'h010);
    repeat (20) step();

    // Precharge-all closes every bank; refresh afterwards is legal.
    issue(C_ACT, 3'd1, 15'd7);
    issue(C_ACT, 3'd3, 15'd9);
    issue(C_PRE, 3'd0, 15'h0400);
    issue(C_RD, 3'd1, 15'h010);
    repeat (4) step();
    issue(C_REF, 3'd0, 15'd0);
    repeat (16) step();

    // Write during a read burst is ignored.
    do_reset();
    issue(C_ACT, 3'd2, 15'd5);
    issue(C_RD, 3'd2, 15'h010);
    repeat (CL + 2) step();
    for (int i = 0; i < 8; i++) begin wdata[i] = 8'h5A; wmask[i] = 1'b0; end
    issue(C_WR, 3'd2, 15'h010);
    repeat (12) step();
    issue(C_RD, 3'd2, 15'h010);
    repeat (16) step();

    // Reset at read beat 2, then confirm banks closed and FSM idle.
    do_reset();
    issue(C_ACT, 3'd2, 15'd5);
    issue(C_RD, 3'd2, 15'h010);
    repeat (CL + 2) step();
    #2;
    do_reset();
    issue(C_RD, 3'd2, 15'h010);
    repeat (16) step();
    do_reset();
    issue(C_ACT, 3'd2, 15'd5);
    issue(C_RD, 3'd2, 15'h010);
    repeat (16) step();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      b = 3'($urandom_range(0, 3));
      a = 15'($urandom);
      if (r < 20) begin
        a[ROW_W-1:0] = ROW_W'($urandom_range(0, 3));
        issue(C_ACT, b, a);
      end else if (r < 80) begin
        a[COL_W-1:3] = (COL_W - 3)'($urandom_range(0, 3));
        if (r < 50) issue(C_RD, b, a);
        else begin
          for (int i = 0; i < 8; i++) begin
            wdata[i] = 8'($urandom_range(0, 254));
            wmask[i] = ($urandom_range(0, 3) == 0);
          end
          issue(C_WR, b, a);
        end
      end else if (r < 88) begin
        a[10] = ($urandom_range(0, 3) == 0);
        issue(C_PRE, b, a);
      end else if (r < 92) begin
        issue((r < 90) ? C_REF : C_MRS, b, a);
      end
      repeat ($urandom_range(0, 6)) step();
      if (n % 75 == 74) begin
        wait_idle();
        step();
        do_reset();
      end
    end

    repeat (40) step();
    check("drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
